bk_adder_pipe: RTL

//  Parametrised, pipelined Brent-Kung adder/subtractor with valid/ready flow control.

---
 rtl/bk_adder_pipe_pkg.sv | 19 +
 rtl/bk_adder_pipe_gp_cell.sv | 16 +
 rtl/bk_adder_pipe.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/bk_adder_pipe_pkg.sv
// Shared types and sizing helpers for the pipelined Brent-Kung adder/subtractor.
package bk_pkg;

    typedef enum logic {BK_ADD = 1'b0, BK_SUB = 1'b1} bk_op_e;

    typedef struct packed {
        logic g;
        logic p;
    } bk_gp_t;

    function automatic int bk_n_lvl(input int width);
        return 2 * $clog2(width) - 1;
    endfunction

    function automatic int bk_latency(input int width, input int lvl_per_stg);
        return 1 + (bk_n_lvl(width) + lvl_per_stg - 1) / lvl_per_stg;
    endfunction

endpackage

// File: rtl/bk_adder_pipe_gp_cell.sv
// One prefix node: black cell combines (g,p); grey cell only produces g because its
// lower operand is already a complete prefix, so the group propagate is known to be 0.
module bk_gp_cell
    import bk_pkg::*;
#(
    parameter bit GREY = 1'b0
) (
    input  bk_gp_t hi_i,
    input  bk_gp_t lo_i,
    output bk_gp_t gp_o
);

    assign gp_o = '{g: hi_i.g | (hi_i.p & lo_i.g),
                    p: GREY ? 1'b0 : (hi_i.p & lo_i.p)};

endmodule

// File: rtl/bk_adder_pipe.sv
// Pipelined Brent-Kung adder/subtractor with valid/ready flow control and a sideband tag.
// Stage 0 registers generate/propagate; later stages each evaluate LVL_PER_STG prefix levels.
module bk_adder_pipe
    import bk_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int LVL_PER_STG = 3,
    parameter int TAG_W       = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_op,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_cin,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH:0]     out_sum,
    output logic               out_ovf,
    output logic [TAG_W-1:0]   out_tag
);

    localparam int LOG_W = $clog2(WIDTH);
    localparam int N_LVL = bk_n_lvl(WIDTH);
    localparam int LAT   = bk_latency(WIDTH, LVL_PER_STG);
    localparam int LAST  = LAT - 1;

    logic [WIDTH-1:0]          b_eff;
    bk_gp_t [WIDTH-1:0]        gp_in;
    logic [LAST:0]             v_q;
    logic [LAST:0]             ld;
    bk_gp_t [WIDTH-1:0]        gp_q  [LAST];
    bk_gp_t [WIDTH-1:0]        stg_d [LAST];
    logic [WIDTH-1:0]          rp_q  [LAST];
    logic [LAST-1:0]           cin_q, am_q, bm_q;
    logic [TAG_W-1:0]          tag_q [LAT];
    logic [WIDTH:0]            sum_q, sum_d;
    logic                      ovf_q, ovf_d;
    bk_gp_t [N_LVL:0][WIDTH-1:0] node;
    bk_gp_t [N_LVL:1][WIDTH-1:0] src;
    bk_gp_t                    cin_node;
    logic [WIDTH-1:0]          cy;
    logic                      unused_p;

    assign b_eff = (bk_op_e'(in_op) == BK_SUB) ? ~in_b : in_b;

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            gp_in[i].g = in_a[i] & b_eff[i];
            gp_in[i].p = in_a[i] ^ b_eff[i];
        end
    end

    // Carry-in is folded in as bit -1 (g=cin, p=0) ahead of the first prefix level.
    assign cin_node = '{g: cin_q[0], p: 1'b0};

    bk_gp_cell #(.GREY(1'b1)) u_cin (
        .hi_i (gp_q[0][0]),
        .lo_i (cin_node),
        .gp_o (node[0][0])
    );

    for (genvar i = 1; i < WIDTH; i++) begin : g_fold
        assign node[0][i] = gp_q[0][i];
    end

    for (genvar k = 1; k <= N_LVL; k++) begin : g_lvl
        localparam bit UP   = (k <= LOG_W);
        localparam int SPAN = UP ? (1 << (k - 1)) : (1 << (2 * LOG_W - k - 1));

        if (k == 1) begin : g_src0
            assign src[k] = node[0];
        end else if ((k - 1) % LVL_PER_STG == 0) begin : g_src_reg
            assign src[k] = gp_q[(k - 1) / LVL_PER_STG];
        end else begin : g_src_comb
            assign src[k] = node[k - 1];
        end

        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            localparam bit ACT = UP ? ((i + 1) % (2 * SPAN) == 0)
                                    : (((i + 1) % (2 * SPAN) == SPAN) && (i >= 2 * SPAN));
            localparam bit GRY = UP ? (i + 1 == 2 * SPAN) : 1'b1;
            if (ACT) begin : g_cell
                bk_gp_cell #(.GREY(GRY)) u_cell (
                    .hi_i (src[k][i]),
                    .lo_i (src[k][i - SPAN]),
                    .gp_o (node[k][i])
                );
            end else begin : g_pass
                assign node[k][i] = src[k][i];
            end
        end
    end

    for (genvar s = 0; s < LAST; s++) begin : g_stg
        if (s == 0) begin : g_in
            assign stg_d[s] = gp_in;
        end else begin : g_mid
            assign stg_d[s] = node[s * LVL_PER_STG];
        end
    end

    // A stage may load when it, or every stage downstream of it, can move on.
    for (genvar s = 0; s <= LAST; s++) begin : g_ld
        assign ld[s] = out_ready | ~(&v_q[LAST:s]);
    end

    always_comb begin
        unused_p = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            cy[i]    = node[N_LVL][i].g;
            unused_p = unused_p ^ node[N_LVL][i].p;
        end
    end

    assign sum_d = {cy[WIDTH-1], rp_q[LAST-1] ^ {cy[WIDTH-2:0], cin_q[LAST-1]}};
    assign ovf_d = (am_q[LAST-1] == bm_q[LAST-1]) & (sum_d[WIDTH-1] != am_q[LAST-1]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_q   <= '0;
            cin_q <= '0;
            am_q  <= '0;
            bm_q  <= '0;
            sum_q <= '0;
            ovf_q <= 1'b0;
            for (int s = 0; s < LAST; s++) begin
                gp_q[s] <= '0;
                rp_q[s] <= '0;
            end
            for (int s = 0; s < LAT; s++) begin
                tag_q[s] <= '0;
            end
        end else begin
            if (ld[0]) begin
                v_q[0]   <= in_valid;
                gp_q[0]  <= stg_d[0];
                rp_q[0]  <= in_a ^ b_eff;
                cin_q[0] <= in_cin;
                am_q[0]  <= in_a[WIDTH-1];
                bm_q[0]  <= b_eff[WIDTH-1];
                tag_q[0] <= in_tag;
            end
            for (int s = 1; s < LAST; s++) begin
                if (ld[s]) begin
                    v_q[s]   <= v_q[s-1];
                    gp_q[s]  <= stg_d[s];
                    rp_q[s]  <= rp_q[s-1];
                    cin_q[s] <= cin_q[s-1];
                    am_q[s]  <= am_q[s-1];
                    bm_q[s]  <= bm_q[s-1];
                    tag_q[s] <= tag_q[s-1];
                end
            end
            if (ld[LAST]) begin
                v_q[LAST]   <= v_q[LAST-1];
                sum_q       <= sum_d;
                ovf_q       <= ovf_d;
                tag_q[LAST] <= tag_q[LAST-1];
            end
        end
    end

    assign in_ready  = rst_n & ld[0];
    assign out_valid = v_q[LAST];
    assign out_sum   = sum_q;
    assign out_ovf   = ovf_q;
    assign out_tag   = tag_q[LAST];

endmodule
